dsp_rr_scheduler: RTL

//  Round-robin scheduler sharing one DSP slice, P = (D+B)*A + C, among N_REQ requesters.

---
 rtl/dsp_rr_scheduler_if.sv | 26 ++
 rtl/dsp_rr_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dsp_rr_scheduler_if.sv
// Requester-side bus of the DSP round-robin scheduler: operand request
// handshake plus the tagged result return path.
interface dsp_rr_scheduler_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) ();
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [N_REQ*18-1:0] req_a;
   logic [N_REQ*18-1:0] req_b;
   logic [N_REQ*18-1:0] req_d;
   logic [N_REQ*48-1:0] req_c;
   logic                res_valid;
   logic [ID_W-1:0]     res_id;
   logic [47:0]         res_p;

   modport master (
      output req_valid, req_a, req_b, req_d, req_c,
      input  req_ready, res_valid, res_id, res_p
   );

   modport slave (
      input  req_valid, req_a, req_b, req_d, req_c,
      output req_ready, res_valid, res_id, res_p
   );
endinterface

// File: rtl/dsp_rr_scheduler.sv
// Round-robin scheduler sharing one DSP slice P = (D+B)*A + C among N_REQ
// requesters, with a tag pipeline that returns each result with its owner ID.
module dsp_rr_scheduler #(
   parameter int N_REQ   = 4,
   parameter int DSP_LAT = 4,
   parameter int ID_W    = $clog2(N_REQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   dsp_rr_scheduler_if.slave            bus,
   input  logic                         pause,
   output logic                         dsp_rst_n,
   output logic [17:0]                  dsp_a,
   output logic [17:0]                  dsp_b,
   output logic [17:0]                  dsp_d,
   output logic [47:0]                  dsp_c,
   input  logic [47:0]                  dsp_p,
   output logic [$clog2(DSP_LAT+1)-1:0] inflight,
   output logic                         idle
);
   localparam int CNT_W = $clog2(DSP_LAT+1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_PAUSED = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nx_s;
   logic [ID_W-1:0]    ptr_r;
   logic [CNT_W-1:0]   inflight_r;
   logic [DSP_LAT-1:0] tag_vld_r;
   logic [ID_W-1:0]    tag_id_r [DSP_LAT];
   logic               found_s;
   logic [ID_W-1:0]    grant_id_s;
   logic [ID_W-1:0]    cand_s;
   logic               xfer_s;
   logic               res_vld_s;

   assign dsp_rst_n     = ~rst;
   assign res_vld_s     = tag_vld_r[DSP_LAT-1];
   assign bus.res_valid = res_vld_s;
   assign bus.res_id    = tag_id_r[DSP_LAT-1];
   assign bus.res_p     = dsp_p;
   assign inflight      = inflight_r;
   assign xfer_s        = found_s;

   // Search from the pointer for the first valid requester; only RUN may grant.
   always_comb begin
      found_s    = 1'b0;
      grant_id_s = '0;
      cand_s     = '0;
      if (state_r == ST_RUN) begin
         for (int k = 0; k < N_REQ; k++) begin
            cand_s = ID_W'((int'(ptr_r) + k) % N_REQ);
            if (!found_s && bus.req_valid[cand_s]) begin
               found_s    = 1'b1;
               grant_id_s = cand_s;
            end else begin
               found_s    = found_s;
            end
         end
      end else begin
         found_s = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next state; DRAIN may leave early when the last result retires this edge.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (pause) state_nx_s = ST_DRAIN;
            else       state_nx_s = ST_RUN;
         end
         ST_DRAIN: begin
            if (!pause)
               state_nx_s = ST_RUN;
            else if ((inflight_r == CNT_W'(0)) ||
                     ((inflight_r == CNT_W'(1)) && res_vld_s))
               state_nx_s = ST_PAUSED;
            else
               state_nx_s = ST_DRAIN;
         end
         ST_PAUSED: begin
            if (!pause) state_nx_s = ST_RUN;
            else        state_nx_s = ST_PAUSED;
         end
         default: state_nx_s = ST_RUN;
      endcase
   end

   // Outputs decoded from state: one-hot grant and idle indication.
   always_comb begin
      bus.req_ready = '0;
      idle          = 1'b0;
      if (found_s) begin
         bus.req_ready[grant_id_s] = 1'b1;
      end else begin
         bus.req_ready = '0;
      end
      case (state_r)
         ST_PAUSED: idle = 1'b1;
         ST_RUN:    idle = (inflight_r == CNT_W'(0)) && (bus.req_valid == '0);
         ST_DRAIN:  idle = 1'b0;
         default:   idle = 1'b0;
      endcase
   end

   // Round-robin pointer and in-flight counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r      <= '0;
         inflight_r <= '0;
      end else begin
         if (xfer_s) begin
            ptr_r <= (grant_id_s == ID_W'(N_REQ - 1)) ? '0 : grant_id_s + ID_W'(1);
         end else begin
            ptr_r <= ptr_r;
         end
         case ({xfer_s, res_vld_s})
            2'b10:   inflight_r <= inflight_r + CNT_W'(1);
            2'b01:   inflight_r <= inflight_r - CNT_W'(1);
            default: inflight_r <= inflight_r;
         endcase
      end
   end

   // Operand registers feeding the DSP; they hold when nothing transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         dsp_a <= 18'd0;
         dsp_b <= 18'd0;
         dsp_d <= 18'd0;
         dsp_c <= 48'd0;
      end else if (xfer_s) begin
         dsp_a <= bus.req_a[int'(grant_id_s)*18 +: 18];
         dsp_b <= bus.req_b[int'(grant_id_s)*18 +: 18];
         dsp_d <= bus.req_d[int'(grant_id_s)*18 +: 18];
         dsp_c <= bus.req_c[int'(grant_id_s)*48 +: 48];
      end else begin
         dsp_a <= dsp_a;
         dsp_b <= dsp_b;
         dsp_d <= dsp_d;
         dsp_c <= dsp_c;
      end
   end

   // Tag pipeline tracks the DSP latency; reset drops every in-flight tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_vld_r <= '0;
         for (int k = 0; k < DSP_LAT; k++) tag_id_r[k] <= '0;
      end else begin
         tag_vld_r[0] <= xfer_s;
         tag_id_r[0]  <= grant_id_s;
         for (int k = 1; k < DSP_LAT; k++) begin
            tag_vld_r[k] <= tag_vld_r[k-1];
            tag_id_r[k]  <= tag_id_r[k-1];
         end
      end
   end
endmodule
